fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the 5-stage pipeline, supporting NUM_SRC source operands per instruction.
- Selects per-operand bypass sources for the instruction in EX.
- Detects load-use hazards.
- Tracks outstanding long-latency (mul/div) writebacks in a register scoreboard and stalls RAW/WAW dependents.
- Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the PC/IF-ID stall and ID/EX flush controls.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 20 ++
 rtl/fwd_hazard_ctrl_ll_scoreboard.sv | 55 +++++
 rtl/fwd_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: bypass select codes,
// stall-reason encoding and default register-file geometry.
package fwd_hazard_ctrl_pkg;

  localparam int DEF_AW       = 5;
  localparam int DEF_NUM_REGS = 32;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_LL    = 2'b11;

  typedef enum logic [1:0] {
    RSN_IDLE,
    RSN_LOAD,
    RSN_SB,
    RSN_STRUCT
  } stall_rsn_e;

endpackage

// File: rtl/fwd_hazard_ctrl_ll_scoreboard.sv
// Pending-writeback scoreboard for long-latency (mul/div) results: one bit per
// architectural register plus an outstanding count that drives the full flag.
module fwd_hazard_ctrl_ll_scoreboard
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int MAX_LL   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic [AW-1:0]       issue_rd,
  input  logic                done,
  input  logic [AW-1:0]       done_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                full
);

  localparam int CW = $clog2(MAX_LL + 1);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [CW-1:0]       count_q;
  logic                issue_ok;
  logic                done_ok;
  logic                inc;
  logic                dec;

  // Clear-then-set ordering keeps a same-register issue+done pending; the count
  // therefore always equals the number of set pending bits.
  always_comb begin
    issue_ok    = issue && (issue_rd != '0) && !full;
    done_ok     = done && pending_q[done_rd];
    inc         = issue_ok && !pending_q[issue_rd];
    dec         = done_ok && !(issue_ok && (issue_rd == done_rd));
    pending_nxt = pending_q;
    if (done_ok)  pending_nxt[done_rd]  = 1'b0;
    if (issue_ok) pending_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_nxt;
      count_q   <= count_q + CW'(inc) - CW'(dec);
    end
  end

  assign pending = pending_q;
  assign full    = (count_q == CW'(MAX_LL));

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard controller for the 5-stage pipeline: bypass mux
// selects for EX operands, load-use / scoreboard / structural stalls, stall counter.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int AW       = DEF_AW,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int MAX_LL   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  id_rs_i,
  input  logic [NUM_SRC-1:0]     id_rs_used_i,
  input  logic [AW-1:0]          id_rd_i,
  input  logic                   id_reg_write_i,
  input  logic                   id_valid_i,
  input  logic [NUM_SRC*AW-1:0]  ex_rs_i,
  input  logic [AW-1:0]          ex_rd_i,
  input  logic                   ex_reg_write_i,
  input  logic                   ex_mem_read_i,
  input  logic [AW-1:0]          mem_rd_i,
  input  logic                   mem_reg_write_i,
  input  logic [AW-1:0]          wb_rd_i,
  input  logic                   wb_reg_write_i,
  input  logic                   ll_issue_i,
  input  logic [AW-1:0]          ll_issue_rd_i,
  input  logic                   ll_done_i,
  input  logic [AW-1:0]          ll_done_rd_i,
  output logic [2*NUM_SRC-1:0]   fwd_sel_o,
  output logic                   stall_o,
  output logic                   bubble_o,
  output logic                   ll_full_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  logic [NUM_REGS-1:0]  pending;
  logic                 ll_full;
  logic [2*NUM_SRC-1:0] fwd_sel;
  logic                 load_use;
  logic                 sb_raw;
  logic                 sb_waw;
  logic                 struct_haz;
  logic                 hazard;
  stall_rsn_e           cur_rsn;
  stall_rsn_e           rsn_q;
  stall_rsn_e           rsn_nxt;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic                 unused_ex_reg_write;

  // Load-use detection keys on the load flag alone; the write flag is redundant for a load.
  assign unused_ex_reg_write = ex_reg_write_i;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fwd_hazard_ctrl_ll_scoreboard #(
    .AW       (AW),
    .NUM_REGS (NUM_REGS),
    .MAX_LL   (MAX_LL)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (ll_issue_i),
    .issue_rd (ll_issue_rd_i),
    .done     (ll_done_i),
    .done_rd  (ll_done_rd_i),
    .pending  (pending),
    .full     (ll_full)
  );

  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i[k*AW +: AW]))
        fwd_sel[2*k +: 2] = FWD_EXMEM;
      else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i[k*AW +: AW]))
        fwd_sel[2*k +: 2] = FWD_MEMWB;
      else if (ll_done_i && (ll_done_rd_i != '0) && (ll_done_rd_i == ex_rs_i[k*AW +: AW]))
        fwd_sel[2*k +: 2] = FWD_LL;
    end
  end

  // A register whose LL result lands this cycle is released so ID can advance
  // and pick the value up through the LL bypass.
  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used_i[k]) begin
        if (ex_mem_read_i && (ex_rd_i != '0) && (ex_rd_i == id_rs_i[k*AW +: AW]))
          load_use = 1'b1;
        if (pending[id_rs_i[k*AW +: AW]] &&
            !(ll_done_i && (ll_done_rd_i == id_rs_i[k*AW +: AW])))
          sb_raw = 1'b1;
      end
    end
    sb_waw     = id_reg_write_i && pending[id_rd_i] &&
                 !(ll_done_i && (ll_done_rd_i == id_rd_i));
    struct_haz = ll_full && ll_issue_i;

    cur_rsn = RSN_IDLE;
    if (id_valid_i) begin
      if (load_use)              cur_rsn = RSN_LOAD;
      else if (sb_raw || sb_waw) cur_rsn = RSN_SB;
      else if (struct_haz)       cur_rsn = RSN_STRUCT;
    end
    hazard = (cur_rsn != RSN_IDLE);
  end

  always_comb begin
    rsn_nxt = RSN_IDLE;
    case (rsn_q)
      RSN_IDLE: rsn_nxt = cur_rsn;
      default:  if (hazard) rsn_nxt = cur_rsn;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsn_q <= RSN_IDLE;
    else        rsn_q <= rsn_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stall_cnt_q <= '0;
    else if (hazard) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  // Combinational outputs are forced low while reset is held.
  assign fwd_sel_o   = rst_n ? fwd_sel : '0;
  assign stall_o     = rst_n && hazard;
  assign bubble_o    = rst_n && hazard;
  assign ll_full_o   = ll_full;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a register-level behavioural model.
module tb_fwd_hazard_ctrl;

  localparam int NUM_SRC  = 2;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;
  localparam int MAX_LL   = 4;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_SRC*AW-1:0] id_rs_i = '0;
  logic [NUM_SRC-1:0]    id_rs_used_i = '0;
  logic [AW-1:0]         id_rd_i = '0;
  logic                  id_reg_write_i = 1'b0;
  logic                  id_valid_i = 1'b0;
  logic [NUM_SRC*AW-1:0] ex_rs_i = '0;
  logic [AW-1:0]         ex_rd_i = '0;
  logic                  ex_reg_write_i = 1'b0;
  logic                  ex_mem_read_i = 1'b0;
  logic [AW-1:0]         mem_rd_i = '0;
  logic                  mem_reg_write_i = 1'b0;
  logic [AW-1:0]         wb_rd_i = '0;
  logic                  wb_reg_write_i = 1'b0;
  logic                  ll_issue_i = 1'b0;
  logic [AW-1:0]         ll_issue_rd_i = '0;
  logic                  ll_done_i = 1'b0;
  logic [AW-1:0]         ll_done_rd_i = '0;
  logic [2*NUM_SRC-1:0]  fwd_sel_o;
  logic                  stall_o;
  logic                  bubble_o;
  logic                  ll_full_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .NUM_SRC(NUM_SRC), .AW(AW), .NUM_REGS(NUM_REGS), .MAX_LL(MAX_LL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_i(id_rs_i), .id_rs_used_i(id_rs_used_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_valid_i(id_valid_i),
    .ex_rs_i(ex_rs_i), .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_mem_read_i(ex_mem_read_i),
    .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
    .ll_issue_i(ll_issue_i), .ll_issue_rd_i(ll_issue_rd_i),
    .ll_done_i(ll_done_i), .ll_done_rd_i(ll_done_rd_i),
    .fwd_sel_o(fwd_sel_o), .stall_o(stall_o), .bubble_o(bubble_o),
    .ll_full_o(ll_full_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic [NUM_SRC*AW-1:0] id_rs;
    logic [NUM_SRC-1:0]    id_used;
    logic [AW-1:0]         id_rd;
    logic                  id_rw;
    logic                  id_v;
    logic [NUM_SRC*AW-1:0] ex_rs;
    logic [AW-1:0]         ex_rd;
    logic                  ex_rw;
    logic                  ex_mr;
    logic [AW-1:0]         mem_rd;
    logic                  mem_rw;
    logic [AW-1:0]         wb_rd;
    logic                  wb_rw;
    logic                  iss;
    logic [AW-1:0]         iss_rd;
    logic                  done;
    logic [AW-1:0]         done_rd;
  } stim_t;

  typedef struct {
    logic [2*NUM_SRC-1:0] fwd;
    logic                 stall;
    logic                 bubble;
    logic                 full;
    logic [CNT_W-1:0]     cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   pend[NUM_REGS];
  int   stall_total = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic int n_pending();
    int n = 0;
    foreach (pend[i]) n += int'(pend[i]);
    return n;
  endfunction

  function automatic logic [AW-1:0] rreg();
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic drive(input stim_t s);
    id_rs_i = s.id_rs;   id_rs_used_i = s.id_used; id_rd_i = s.id_rd;
    id_reg_write_i = s.id_rw; id_valid_i = s.id_v;
    ex_rs_i = s.ex_rs;   ex_rd_i = s.ex_rd; ex_reg_write_i = s.ex_rw;
    ex_mem_read_i = s.ex_mr;
    mem_rd_i = s.mem_rd; mem_reg_write_i = s.mem_rw;
    wb_rd_i = s.wb_rd;   wb_reg_write_i = s.wb_rw;
    ll_issue_i = s.iss;  ll_issue_rd_i = s.iss_rd;
    ll_done_i = s.done;  ll_done_rd_i = s.done_rd;
  endtask

  // One clock of stimulus: predict this cycle's outputs, then advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    bit ld, raw, waw, st, haz, full;
    logic [AW-1:0] r;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(s);
    full = (n_pending() == MAX_LL);
    e.fwd = '0;
    ld = 0; raw = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      r = s.ex_rs[k*AW +: AW];
      if (r != 0) begin
        if (s.mem_rw && s.mem_rd == r)    e.fwd[2*k +: 2] = 2'b10;
        else if (s.wb_rw && s.wb_rd == r) e.fwd[2*k +: 2] = 2'b01;
        else if (s.done && s.done_rd == r) e.fwd[2*k +: 2] = 2'b11;
      end
      r = s.id_rs[k*AW +: AW];
      if (s.id_used[k]) begin
        if (s.ex_mr && s.ex_rd != 0 && s.ex_rd == r) ld = 1;
        if (pend[r] && !(s.done && s.done_rd == r)) raw = 1;
      end
    end
    waw = s.id_rw && pend[s.id_rd] && !(s.done && s.done_rd == s.id_rd);
    st  = full && s.iss;
    haz = s.id_v && (ld || raw || waw || st);
    e.stall = haz; e.bubble = haz; e.full = full; e.cnt = CNT_W'(stall_total);
    exp_q.push_back(e);
    if (haz && stall_total < CNT_MAX) stall_total++;
    if (s.done) pend[s.done_rd] = 0;
    if (s.iss && s.iss_rd != 0 && !full) pend[s.iss_rd] = 1;
  endtask

  task automatic reset_mid(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    drive(s);
    rst_n = 1'b0;
    #1;
    chk("rst_full_now", 32'(ll_full_o), 32'd0);
    chk("rst_cnt_now", 32'(stall_cnt_o), 32'd0);
    foreach (pend[i]) pend[i] = 0;
    stall_total = 0;
    e = '{default: '0};
    exp_q.push_back(e);
    @(negedge clk); #1;
    drive(idle());
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("fwd_sel", 32'(fwd_sel_o), 32'(mon_e.fwd));
        chk("stall", 32'(stall_o), 32'(mon_e.stall));
        chk("bubble", 32'(bubble_o), 32'(mon_e.bubble));
        chk("ll_full", 32'(ll_full_o), 32'(mon_e.full));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cnt;
    foreach (pend[i]) pend[i] = 0;
    #2;
    s = idle();
    s.mem_rw = 1; s.mem_rd = 5; s.ex_rs = {AW'(0), AW'(5)};
    reset_mid(s);

    // Forwarding priority
    s = idle();
    s.mem_rw = 1; s.mem_rd = 5; s.wb_rw = 1; s.wb_rd = 5; s.ex_rs = {AW'(0), AW'(5)};
    apply(s);
    s.mem_rw = 0; apply(s);
    s.mem_rw = 1; s.mem_rd = 0; s.wb_rd = 0; s.ex_rs = {AW'(0), AW'(0)}; apply(s);

    // Load-use, then the same with operand 1 unused
    s = idle();
    s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 7; s.id_v = 1;
    s.id_rs = {AW'(7), AW'(2)}; s.id_used = 2'b11;
    apply(s);
    s.id_used = 2'b01; apply(s);
    apply(idle());

    // Long-latency RAW on x9, released on the done cycle with LL bypass
    s = idle(); s.iss = 1; s.iss_rd = 9; apply(s);
    s = idle(); s.id_v = 1; s.id_rs = {AW'(0), AW'(9)}; s.id_used = 2'b01;
    repeat (10) apply(s);
    s.done = 1; s.done_rd = 9; s.ex_rs = {AW'(9), AW'(0)}; apply(s);
    apply(idle());

    // Fill the scoreboard, WAW on x4, structural, then drain one
    foreach (s.id_rs[i]) s.id_rs[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.iss = 1;
      s.iss_rd = (i == 0) ? AW'(3) : (i == 1) ? AW'(4) : (i == 2) ? AW'(6) : AW'(8);
      apply(s);
    end
    s = idle(); s.id_v = 1; s.id_rw = 1; s.id_rd = 4; apply(s);
    s = idle(); s.id_v = 1; s.iss = 1; s.iss_rd = 10; apply(s);
    s = idle(); s.done = 1; s.done_rd = 3; apply(s);
    apply(idle());

    // Same-cycle issue+done on x12; done on a non-pending register
    s = idle(); s.done = 1; s.done_rd = 4; apply(s);
    s.done_rd = 6; apply(s);
    s.done_rd = 8; apply(s);
    s = idle(); s.iss = 1; s.iss_rd = 12; apply(s);
    s.done = 1; s.done_rd = 12; apply(s);
    s = idle(); s.id_v = 1; s.id_rs = {AW'(12), AW'(0)}; s.id_used = 2'b10; apply(s);
    s = idle(); s.done = 1; s.done_rd = 20; apply(s);
    s = idle(); s.done = 1; s.done_rd = 12; apply(s);

    // Reset with three outstanding, late done, then counter saturation
    for (int i = 1; i <= 3; i++) begin
      s = idle(); s.iss = 1; s.iss_rd = AW'(i); apply(s);
    end
    s = idle(); s.id_v = 1; s.id_rs = {AW'(0), AW'(1)}; s.id_used = 2'b01;
    repeat (3) apply(s);
    s = idle(); s.mem_rw = 1; s.mem_rd = 5; s.ex_rs = {AW'(5), AW'(5)};
    s.ex_mr = 1; s.ex_rd = 6; s.id_v = 1; s.id_rs = {AW'(6), AW'(6)}; s.id_used = 2'b11;
    reset_mid(s);
    s = idle(); s.done = 1; s.done_rd = 1; apply(s);
    s = idle(); s.ex_mr = 1; s.ex_rd = 7; s.id_v = 1; s.id_rs = {AW'(0), AW'(7)}; s.id_used = 2'b01;
    repeat (70) apply(s);
    apply(idle());

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      for (int k = 0; k < NUM_SRC; k++) begin
        s.id_rs[k*AW +: AW] = rreg();
        s.ex_rs[k*AW +: AW] = rreg();
      end
      s.id_used = NUM_SRC'($urandom);
      s.id_rd = rreg();   s.id_rw = 1'($urandom); s.id_v = ($urandom_range(0, 3) != 0);
      s.ex_rd = rreg();   s.ex_rw = 1'($urandom); s.ex_mr = ($urandom_range(0, 3) == 0);
      s.mem_rd = rreg();  s.mem_rw = 1'($urandom);
      s.wb_rd = rreg();   s.wb_rw = 1'($urandom);
      s.iss = ($urandom_range(0, 2) == 0); s.iss_rd = rreg();
      s.done = ($urandom_range(0, 2) == 0); s.done_rd = rreg();
      if (n == 800) reset_mid(s);
      else apply(s);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
